// File: rtl/cross_bar_master_bridge.sv
// Crossbar master bridge: queues requester commands in a small FIFO, runs them one at a
// time on the crossbar master port and returns each completion on a response stream.
module cross_bar_master_bridge #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [AWIDTH-1:0]      s_addr,
    input  logic                   s_cmd,
    input  logic [DWIDTH-1:0]      s_wdata,
    output logic                   m_req,
    output logic [AWIDTH-1:0]      m_addr,
    output logic                   m_cmd,
    output logic [DWIDTH-1:0]      m_wdata,
    input  logic                   m_ack,
    input  logic [DWIDTH-1:0]      m_rdata,
    input  logic                   m_resp,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [DWIDTH-1:0]      r_rdata,
    output logic                   r_cmd,
    output logic                   r_resp,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AWIDTH + 1 + DWIDTH;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    // Command FIFO storage and bookkeeping
    logic [EW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW:0]       count_reg;
    logic [PW:0]       count_next;
    logic              push;
    logic              pop;
    logic [AWIDTH-1:0] head_addr;
    logic              head_cmd;
    logic [DWIDTH-1:0] head_wdata;

    // Controller state and registered outputs
    state_t            state_reg;
    state_t            state_next;
    logic              m_req_reg;
    logic              m_req_next;
    logic [AWIDTH-1:0] m_addr_reg;
    logic [AWIDTH-1:0] m_addr_next;
    logic              m_cmd_reg;
    logic              m_cmd_next;
    logic [DWIDTH-1:0] m_wdata_reg;
    logic [DWIDTH-1:0] m_wdata_next;
    logic              echo_cmd_reg;
    logic              echo_cmd_next;
    logic              r_valid_reg;
    logic              r_valid_next;
    logic [DWIDTH-1:0] r_rdata_reg;
    logic [DWIDTH-1:0] r_rdata_next;
    logic              r_cmd_reg;
    logic              r_cmd_next;
    logic              r_resp_reg;
    logic              r_resp_next;

    assign s_ready    = (count_reg != FULL_COUNT);
    assign push       = s_valid && s_ready;
    assign fifo_count = count_reg;

    // Head is read asynchronously so IDLE can load the request fields in a single cycle.
    assign {head_addr, head_cmd, head_wdata} = mem[rd_ptr_reg];

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {s_addr, s_cmd, s_wdata};
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (PW + 1)'(1);
            2'b01:   count_next = count_reg - (PW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pop           = 1'b0;
        m_req_next    = m_req_reg;
        m_addr_next   = m_addr_reg;
        m_cmd_next    = m_cmd_reg;
        m_wdata_next  = m_wdata_reg;
        echo_cmd_next = echo_cmd_reg;
        r_valid_next  = r_valid_reg;
        r_rdata_next  = r_rdata_reg;
        r_cmd_next    = r_cmd_reg;
        r_resp_next   = r_resp_reg;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    state_next   = REQ;
                    m_req_next   = 1'b1;
                    m_addr_next  = head_addr;
                    m_cmd_next   = head_cmd;
                    m_wdata_next = head_wdata;
                end
            end
            REQ: begin
                if (m_ack) begin
                    pop           = 1'b1;
                    echo_cmd_next = head_cmd;
                    m_req_next    = 1'b0;
                    state_next    = RESP;
                end
            end
            RESP: begin
                // Crossbar return data is only valid in the cycle after the ack.
                r_rdata_next = m_rdata;
                r_resp_next  = m_resp;
                r_cmd_next   = echo_cmd_reg;
                r_valid_next = 1'b1;
                state_next   = HOLD;
            end
            HOLD: begin
                if (r_ready) begin
                    r_valid_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg    <= IDLE;
            m_req_reg    <= 1'b0;
            m_addr_reg   <= '0;
            m_cmd_reg    <= 1'b0;
            m_wdata_reg  <= '0;
            echo_cmd_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_rdata_reg  <= '0;
            r_cmd_reg    <= 1'b0;
            r_resp_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            m_req_reg    <= m_req_next;
            m_addr_reg   <= m_addr_next;
            m_cmd_reg    <= m_cmd_next;
            m_wdata_reg  <= m_wdata_next;
            echo_cmd_reg <= echo_cmd_next;
            r_valid_reg  <= r_valid_next;
            r_rdata_reg  <= r_rdata_next;
            r_cmd_reg    <= r_cmd_next;
            r_resp_reg   <= r_resp_next;
        end
    end

    assign m_req   = m_req_reg;
    assign m_addr  = m_addr_reg;
    assign m_cmd   = m_cmd_reg;
    assign m_wdata = m_wdata_reg;
    assign r_valid = r_valid_reg;
    assign r_rdata = r_rdata_reg;
    assign r_cmd   = r_cmd_reg;
    assign r_resp  = r_resp_reg;

endmodule
